uart_rx: RTL
============

# uart_rx

Serial receiver for the host UART link (500000 bps, 8N1) in the 100 MHz system clock domain. It sits between the buffered UART RX pin and the UART command controller. It oversamples the line with a bit-period counter, recovers one byte per frame LSB-first, and presents it on a one-entry valid/ready output register. Framing errors and overruns are flagged as single-cycle pulses.

## Interface
- CLKS_PER_BIT, 200, clock cycles per bit (100 MHz / 500000); legal range 8..65535
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  synchronous reset, active-low
- rx_in  in  1  UART line, idle high, treated as asynchronous
- m_data  out  8  received byte
- m_valid  out  1  m_data holds an unconsumed byte
- m_ready  in  1  consumer accepts m_data on a clk edge where m_valid && m_ready
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: byte completed while the register was full and not being drained
- busy  out  1  high in every state except IDLE

## Operation
- Synchronizer: two flops on rx_in produce rx_s. Reset value is 1 (idle), so reset never causes a false start.
- Bit counter width is clog2(CLKS_PER_BIT). HALF = CLKS_PER_BIT/2, using integer division.
- State machine:
  - IDLE: on rx_s == 0, go to START and clear the counter.
  - START: count HALF cycles, then sample rx_s. If the sample is 1, it is a glitch: return to IDLE with no output. If 0, go to DATA with bit index 0.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift bit[index], LSB first. After index 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - If 1: the frame is good. Deliver the byte and return to IDLE at once, at mid-stop-bit, so a back-to-back start edge is caught.
    - If 0: pulse frame_err, discard the byte, and go to BREAK.
  - BREAK: wait until rx_s == 1, then go to IDLE. A held-low line produces no further frames or errors.
- Delivery on a good frame:
  - If m_valid == 0, or m_ready == 1 in the same cycle: load m_data and set m_valid = 1.
  - Otherwise: keep the old m_data and m_valid, drop the new byte, and pulse overrun.
- Handshake: a handshake with no new byte arriving clears m_valid on the next edge. m_data is held until it is reloaded.
- Reset (rst_n == 0 at a clk edge), taking effect that edge:
  - State goes to IDLE and all counters clear.
  - m_data = 0x00, m_valid = 0, frame_err = 0, overrun = 0, busy = 0.
  - A partial frame is discarded.

## Timing
- T0 is the first clk edge that samples rx_in low at the start of a frame.
- State leaves IDLE at edge T0+2, after the synchronizer.
- Start-bit sample at T0+2+HALF.
- Data bit k (k = 0..7) sampled at T0+2+HALF+(k+1)*CLKS_PER_BIT.
- Stop sample at S = T0+2+HALF+9*CLKS_PER_BIT.
- m_valid (good frame), frame_err, or overrun is registered at edge S and visible in the cycle after S.
- frame_err and overrun are exactly one cycle wide.
- busy falls at edge S on a good frame. It falls at the edge after rx_s returns high on a framing error.
- Throughput: one byte per 10 bit times with zero idle gap. Tolerates ±4% baud mismatch at the default parameter.
- m_ready has no combinational path to any output.

## Test plan
- **Single byte:** rx_in carries 0xA5 at 200 clk/bit, m_ready = 1 → m_valid high for exactly 1 cycle at S+1 = T0+1903, m_data = 0xA5, frame_err = overrun = 0.
- **Glitch rejection:** rx_in low for 50 cycles, then high → busy high from T0+2 to T0+102, no m_valid, no frame_err.
- **Framing error and break:** 0x3C sent with a low stop bit → frame_err pulse at S+1, no m_valid. Line then held low 2000 cycles → no further pulses, busy stays high. Release the line, then send 0x81 → m_data = 0x81, m_valid asserts.
- **Overrun:** m_ready = 0; send 0x11, then 0x22 → m_data = 0x11 stays, overrun pulses 1 cycle at the 0x22 stop sample. Then m_ready = 1 for one cycle → m_valid falls on the next edge.
- **Back-to-back:** 0x00 then 0xFF with no idle gap, m_ready tied 1 → two m_valid pulses spaced exactly 2000 cycles apart, data 0x00 then 0xFF.
- **Reset mid-frame:** rst_n = 0 for 1 cycle during data bit 4 → busy = 0 and m_valid = 0 on the next edge, no output from the partial frame. The following full frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// Output side of the UART receiver: received byte with a valid/ready handshake
// plus the framing-error, overrun and busy status lines.
interface uart_rx_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        output m_data,
        output m_valid,
        output frame_err,
        output overrun,
        output busy,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  frame_err,
        input  overrun,
        input  busy,
        output m_ready
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the line, samples mid-bit with a bit-period
// counter and holds each good byte in a one-entry valid/ready output register.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 200
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx_in,
    uart_rx_if.master m
);
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             rx_s;
    logic             half_tick;
    logic             full_tick;

    assign rx_s      = sync_q[1];
    assign half_tick = (cnt_q == HALF_M1);
    assign full_tick = (cnt_q == FULL_M1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!rx_s) state_d = START;
            START:   if (half_tick) state_d = rx_s ? IDLE : DATA;
            DATA:    if (full_tick && (idx_q == 3'd7)) state_d = STOP;
            STOP:    if (full_tick) state_d = rx_s ? IDLE : BRK;
            BRK:     if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A good frame is delivered only if the register is empty or being drained
    // on this very edge; otherwise the new byte is dropped and overrun pulses.
    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q && !m.m_ready;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
            end
            START: begin
                if (half_tick) begin
                    cnt_d = '0;
                    idx_d = '0;
                end
            end
            DATA: begin
                if (full_tick) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                end
            end
            STOP: begin
                if (full_tick) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        if (!valid_q || m.m_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            BRK: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Synchronizer resets to idle-high so leaving reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_in};
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign m.m_data    = data_q;
    assign m.m_valid   = valid_q;
    assign m.frame_err = ferr_q;
    assign m.overrun   = ovr_q;
    assign m.busy      = (state_q != IDLE);
endmodule
